fifo_ptr_ctrl: RTL and testbench

Pointer/flag controller sitting directly upstream of the 8-entry, 10-bit FIFO memory: it turns producer `push` and consumer `pop` requests into the memory's `wr_enable`/`rd_enable`/`wr_ptr`/`rd_ptr`. It also tracks occupancy, raises full/empty and programmable almost-full/almost-empty flags, and traps overflow/underflow into an error state.

---
 rtl/fifo_ctrl_pkg.sv | 17 +
 rtl/fifo_ptr_ctrl_if.sv | 35 +++
 rtl/fifo_flags.sv | 19 +
 rtl/fifo_ptr_ctrl.sv | 115 +++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO pointer controller, its flag logic and the attached memory.
package fifo_ctrl_pkg;

    localparam int PTR_WIDTH  = 3;
    localparam int DEPTH      = 1 << PTR_WIDTH;
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;
    localparam int DATA_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Producer/consumer requests, thresholds and memory/status outputs of the FIFO pointer controller.
interface fifo_ptr_ctrl_if;
    import fifo_ctrl_pkg::*;

    logic                 push;
    logic                 pop;
    logic [CNT_WIDTH-1:0] thr_almost_full;
    logic [CNT_WIDTH-1:0] thr_almost_empty;
    logic                 wr_enable;
    logic                 rd_enable;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 data_valid;
    logic                 overflow_err;
    logic                 underflow_err;
    logic [2:0]           state;

    modport master (
        output push, pop, thr_almost_full, thr_almost_empty,
        input  wr_enable, rd_enable, wr_ptr, rd_ptr, count, full, empty,
               almost_full, almost_empty, data_valid, overflow_err, underflow_err, state
    );

    modport slave (
        input  push, pop, thr_almost_full, thr_almost_empty,
        output wr_enable, rd_enable, wr_ptr, rd_ptr, count, full, empty,
               almost_full, almost_empty, data_valid, overflow_err, underflow_err, state
    );

endinterface

// File: rtl/fifo_flags.sv
// Combinational occupancy flags; shared with the arbiter FIFOs downstream.
module fifo_flags
    import fifo_ctrl_pkg::*;
(
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic [CNT_WIDTH-1:0] thr_af_i,
    input  logic [CNT_WIDTH-1:0] thr_ae_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o
);

    assign full_o         = (count_i == CNT_WIDTH'(DEPTH));
    assign empty_o        = (count_i == '0);
    assign almost_full_o  = (count_i >= thr_af_i);
    assign almost_empty_o = (count_i <= thr_ae_i);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for an 8-entry FIFO memory with sticky overflow/underflow trapping.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_RESET  | held in reset, nothing accepted
// ST_INIT   | one cycle, almost-full/empty thresholds latched
// ST_IDLE   | operational, FIFO empty
// ST_ACTIVE | operational, FIFO holds at least one word
// ST_ERROR  | overflow or underflow seen, frozen until reset
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
(
    input logic            clk,
    input logic            reset,
    fifo_ptr_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] thr_af_q, thr_af_d;
    logic [CNT_WIDTH-1:0] thr_ae_q, thr_ae_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 dv_q, dv_d;

    logic full, empty;
    logic in_op, push_acc, pop_acc, ovf_ev, udf_ev;

    fifo_flags u_flags (
        .count_i        (count_q),
        .thr_af_i       (thr_af_q),
        .thr_ae_i       (thr_ae_q),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (bus.almost_full),
        .almost_empty_o (bus.almost_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            thr_af_q <= CNT_WIDTH'(DEPTH);
            thr_ae_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            thr_af_q <= thr_af_d;
            thr_ae_q <= thr_ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            dv_q     <= dv_d;
        end
    end

    always_comb begin
        in_op    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        push_acc = in_op & bus.push & ~full;
        pop_acc  = in_op & bus.pop & ~empty;
        ovf_ev   = in_op & bus.push & full;
        udf_ev   = in_op & bus.pop & empty;

        state_d  = state_q;
        thr_af_d = thr_af_q;
        thr_ae_d = thr_ae_q;
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push_acc);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop_acc);
        count_d  = count_q + CNT_WIDTH'(push_acc) - CNT_WIDTH'(pop_acc);
        ovf_d    = ovf_q | ovf_ev;
        udf_d    = udf_q | udf_ev;
        dv_d     = pop_acc;

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                thr_af_d = bus.thr_almost_full;
                thr_ae_d = bus.thr_almost_empty;
                state_d  = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                // The legal half of a mixed push+pop still lands before the trap.
                if (ovf_ev || udf_ev)
                    state_d = ST_ERROR;
                else if (count_d != '0)
                    state_d = ST_ACTIVE;
                else
                    state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    assign bus.wr_enable     = push_acc;
    assign bus.rd_enable     = pop_acc;
    assign bus.wr_ptr        = wr_ptr_q;
    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.data_valid    = dv_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench: a queue-based FIFO model predicts every cycle; monitors compare after each edge.
module tb_fifo_ptr_ctrl;
    import fifo_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if bus();

    fifo_ptr_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for the attached memory so data alignment is observable.
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bus.wr_enable) mem[bus.wr_ptr] <= wdata;
        if (bus.rd_enable) rdata <= mem[bus.rd_ptr];
    end

    typedef struct {
        int state;
        int count;
        int wr_ptr;
        int rd_ptr;
        bit full;
        bit empty;
        bit af;
        bit ae;
        bit ovf;
        bit udf;
        bit dv;
        int word;
    } exp_t;

    typedef struct {
        bit we;
        bit re;
    } en_t;

    exp_t exp_q[$];
    en_t  en_q[$];

    // Reference model: contents as a queue of words, pointers as totals mod depth.
    int m_phase;
    int m_dq[$];
    int wr_tot, rd_tot;
    int m_af, m_ae;
    bit m_ovf, m_udf;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input int req);
        vectors++;
        if (act !== 32'(req)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit p, input bit q, input int word);
        exp_t e;
        en_t  en;
        bit   dpush, dpop, ovf_hit, udf_hit;
        int   n;
        @(negedge clk);
        reset    = r;
        bus.push = p;
        bus.pop  = q;
        wdata    = DATA_WIDTH'(word);
        dpush = 0; dpop = 0; ovf_hit = 0; udf_hit = 0;
        e.dv = 0; e.word = 0;
        n = m_dq.size();
        if (m_phase == 2 || m_phase == 3) begin
            dpop    = q && n > 0;
            dpush   = p && n < DEPTH;
            ovf_hit = p && n == DEPTH;
            udf_hit = q && n == 0;
        end
        en.we = dpush;
        en.re = dpop;
        en_q.push_back(en);
        if (r) begin
            m_phase = 0;
            m_dq.delete();
            wr_tot = 0; rd_tot = 0;
            m_af = DEPTH; m_ae = 0;
            m_ovf = 0; m_udf = 0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: begin
                    m_af = int'(bus.thr_almost_full);
                    m_ae = int'(bus.thr_almost_empty);
                    m_phase = 2;
                end
                2, 3: begin
                    if (dpop) begin
                        e.dv = 1;
                        e.word = m_dq.pop_front();
                        rd_tot++;
                    end
                    if (dpush) begin
                        m_dq.push_back(word & ((1 << DATA_WIDTH) - 1));
                        wr_tot++;
                    end
                    if (ovf_hit) m_ovf = 1;
                    if (udf_hit) m_udf = 1;
                    if (ovf_hit || udf_hit) m_phase = 4;
                    else m_phase = (m_dq.size() > 0) ? 3 : 2;
                end
                default: ;
            endcase
        end
        e.state  = m_phase;
        e.count  = m_dq.size();
        e.wr_ptr = wr_tot % DEPTH;
        e.rd_ptr = rd_tot % DEPTH;
        e.full   = (e.count == DEPTH);
        e.empty  = (e.count == 0);
        e.af     = (e.count >= m_af);
        e.ae     = (e.count <= m_ae);
        e.ovf    = m_ovf;
        e.udf    = m_udf;
        exp_q.push_back(e);
    endtask

    always begin : out_mon
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",         bus.state,         e.state);
            chk("count",         bus.count,         e.count);
            chk("wr_ptr",        bus.wr_ptr,        e.wr_ptr);
            chk("rd_ptr",        bus.rd_ptr,        e.rd_ptr);
            chk("full",          bus.full,          e.full);
            chk("empty",         bus.empty,         e.empty);
            chk("almost_full",   bus.almost_full,   e.af);
            chk("almost_empty",  bus.almost_empty,  e.ae);
            chk("overflow_err",  bus.overflow_err,  e.ovf);
            chk("underflow_err", bus.underflow_err, e.udf);
            chk("data_valid",    bus.data_valid,    e.dv);
            if (e.dv) chk("rd_data", rdata, e.word);
        end
    end

    always begin : en_mon
        en_t x;
        @(negedge clk);
        #2;
        if (en_q.size() > 0) begin
            x = en_q.pop_front();
            chk("wr_enable", bus.wr_enable, x.we);
            chk("rd_enable", bus.rd_enable, x.re);
        end
    end

    task automatic restart(input int taf, input int tae);
        bus.thr_almost_full  = CNT_WIDTH'(taf);
        bus.thr_almost_empty = CNT_WIDTH'(tae);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        int bias_p, bias_q;
        bus.push = 0;
        bus.pop  = 0;
        wdata    = '0;
        bus.thr_almost_full  = 4'd6;
        bus.thr_almost_empty = 4'd2;
        m_phase = 0; wr_tot = 0; rd_tot = 0;
        m_af = DEPTH; m_ae = 0; m_ovf = 0; m_udf = 0;

        cyc(1, 0, 0, 0);
        restart(6, 2);

        cyc(0, 1, 0, 'h3C5);
        cyc(0, 1, 0, 'h3FF);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, int'($urandom));
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 4; i++) cyc(0, 1, 0, int'($urandom));
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, int'($urandom));
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

        for (int i = 0; i < 8; i++) cyc(0, 1, 0, int'($urandom));
        cyc(0, 1, 1, 'h155);
        for (int i = 0; i < 3; i++) cyc(0, 1, i % 2 == 0, int'($urandom));

        restart(6, 2);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, 'h2AA);
        cyc(0, 0, 0, 0);
        restart(5, 3);
        cyc(0, 1, 1, 'h0F0);

        restart(4, 4);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, int'($urandom));
        cyc(0, 1, 0, 'h111);

        for (int round = 0; round < 25; round++) begin
            restart(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
            bias_p = int'($urandom_range(20, 80));
            bias_q = int'($urandom_range(20, 80));
            for (int i = 0; i < 40; i++)
                cyc(0, $urandom_range(0, 99) < bias_p, $urandom_range(0, 99) < bias_q,
                    int'($urandom));
        end

        @(negedge clk);
        bus.push = 0;
        bus.pop  = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size() + en_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
